// File: rtl/airi5c_float_rounder_pkg.sv
// Shared definitions for the binary32 rounding/packing stage:
// rounding-mode codes, fflags bit positions, overflow result constants
// and the operand bundle carried between the rounder's internal stages.
package airi5c_float_rounder_pkg;

  localparam logic [2:0] FPU_RM_RNE = 3'b000;
  localparam logic [2:0] FPU_RM_RTZ = 3'b001;
  localparam logic [2:0] FPU_RM_RDN = 3'b010;
  localparam logic [2:0] FPU_RM_RUP = 3'b011;
  localparam logic [2:0] FPU_RM_RMM = 3'b100;

  localparam int FPU_FLAG_NV = 4;
  localparam int FPU_FLAG_DZ = 3;
  localparam int FPU_FLAG_OF = 2;
  localparam int FPU_FLAG_UF = 1;
  localparam int FPU_FLAG_NX = 0;

  // Magnitudes only; the sign is prepended by the packer.
  localparam logic [30:0] FPU_MAX_FINITE = 31'h7F7F_FFFF;
  localparam logic [30:0] FPU_INF        = 31'h7F80_0000;

  // Unrounded operand: exp is a signed, biased exponent.
  typedef struct packed {
    logic        sgn;
    logic [9:0]  exp;
    logic [23:0] man;
    logic        rnd;
    logic        stk;
  } rnd_op_t;

endpackage

// File: rtl/airi5c_rshifter.sv
// Logical right shifter with sticky collection.
//   din    : value to shift
//   shamt  : shift distance (values >= DATA_W shift everything out)
//   dout   : din >> shamt
//   sticky : OR of every bit shifted out
module airi5c_rshifter #(
  parameter int DATA_W  = 26,
  parameter int SHIFT_W = 5
) (
  input  logic [DATA_W-1:0]  din,
  input  logic [SHIFT_W-1:0] shamt,
  output logic [DATA_W-1:0]  dout,
  output logic               sticky
);

  // Shift into a double-width window; the lower half holds the lost bits.
  logic [2*DATA_W-1:0] ext;

  assign ext    = {din, {DATA_W{1'b0}}} >> shamt;
  assign dout   = ext[2*DATA_W-1:DATA_W];
  assign sticky = |ext[DATA_W-1:0];

endmodule

// File: rtl/airi5c_float_rounder.sv
// Rounding/packing stage behind the FPU add/sub unit (shareable by mul/div).
// Takes an unrounded sign/exponent/mantissa with round and sticky bits,
// denormalises tiny results, rounds per rm, detects overflow and packs a
// binary32 word with fflags {NV,DZ,OF,UF,NX}.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   kill               abort the running operation, clear outputs
//   load               start strobe; all inputs sampled on this edge
//   rm                 rounding mode (RNE/RTZ/RDN/RUP/RMM, others as RNE)
//   man_in, exp_in,    unrounded mantissa (bit 23 hidden), signed biased
//   sgn_in             exponent, sign
//   round_in,sticky_in guard and sticky bits below the mantissa LSB
//   iv_in              invalid-operation flag from the producing unit
//   final_in           operand already special; pack as-is
//   result, fflags     packed result and exception flags
//   ready              one-cycle pulse when result/fflags are valid
//   busy               operation in flight
//
// Build option: FPU_FLUSH_TO_ZERO_EN flushes every result with exp<=0 to a
// signed zero (raising UF|NX when anything non-zero was discarded).
module airi5c_float_rounder
  import airi5c_float_rounder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  input  logic        load,
  input  logic [2:0]  rm,
  input  logic [23:0] man_in,
  input  logic [9:0]  exp_in,
  input  logic        sgn_in,
  input  logic        round_in,
  input  logic        sticky_in,
  input  logic        iv_in,
  input  logic        final_in,
  output logic [31:0] result,
  output logic [4:0]  fflags,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_DENORM = 4'b0010,
    S_ROUND  = 4'b0100,
    S_PACK   = 4'b1000
  } state_t;

  state_t state_q, state_d;

  function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                     input logic r, input logic s, input logic lsb);
    case (mode)
      FPU_RM_RTZ: round_inc = 1'b0;
      FPU_RM_RDN: round_inc = sgn & (r | s);
      FPU_RM_RUP: round_inc = !sgn & (r | s);
      FPU_RM_RMM: round_inc = r;
      default:    round_inc = r & (s | lsb);
    endcase
  endfunction

  function automatic logic ovf_to_inf(input logic [2:0] mode, input logic sgn);
    case (mode)
      FPU_RM_RTZ: ovf_to_inf = 1'b0;
      FPU_RM_RDN: ovf_to_inf = sgn;
      FPU_RM_RUP: ovf_to_inf = !sgn;
      default:    ovf_to_inf = 1'b1;
    endcase
  endfunction

  rnd_op_t     op_p0, op_p1, denorm_d;
  logic [2:0]  rm_p0;
  logic        iv_p0;
  logic        ftz_d, ftz_p1;
  logic        sgn_p2, nx_p2, of_p2;
  logic [7:0]  exp_p2;
  logic [23:0] man_p2;
  logic [31:0] result_q, pack_res;
  logic [4:0]  fflags_q, pack_flags;
  logic        ready_fin_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DENORM: state_d = S_ROUND;
      S_ROUND:  state_d = S_PACK;
      S_PACK:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (load) state_d = final_in ? S_IDLE : S_DENORM;
    if (kill) state_d = S_IDLE;
  end

  // ---- DENORM: bring exp<=0 results into the subnormal range ----
`ifdef FPU_FLUSH_TO_ZERO_EN
  always_comb begin
    denorm_d = op_p0;
    ftz_d    = 1'b0;
    if ($signed(op_p0.exp) <= 10'sd0) begin
      ftz_d        = |{op_p0.man, op_p0.rnd, op_p0.stk};
      denorm_d.exp = '0;
      denorm_d.man = '0;
      denorm_d.rnd = 1'b0;
      denorm_d.stk = 1'b0;
    end
  end
`else
  logic signed [10:0] shift_full;
  logic [4:0]         shamt;
  logic [25:0]        sh_out;
  logic               sh_sticky;

  // Sticky rides along at bit 0, so it stays in the sticky slot after any shift.
  assign shift_full = 11'sd1 - $signed({op_p0.exp[9], op_p0.exp});
  assign shamt      = (shift_full > 11'sd26) ? 5'd26 : shift_full[4:0];

  airi5c_rshifter #(.DATA_W(26), .SHIFT_W(5)) u_rshifter (
    .din    ({op_p0.man, op_p0.rnd, op_p0.stk}),
    .shamt  (shamt),
    .dout   (sh_out),
    .sticky (sh_sticky)
  );

  always_comb begin
    denorm_d = op_p0;
    ftz_d    = 1'b0;
    if ($signed(op_p0.exp) <= 10'sd0) begin
      denorm_d.exp = '0;
      denorm_d.man = sh_out[25:2];
      denorm_d.rnd = sh_out[1];
      denorm_d.stk = sh_out[0] | sh_sticky;
    end
  end
`endif

  // ---- ROUND: increment, renormalise on carry, detect overflow ----
  logic               inc;
  logic [24:0]        sum;
  logic signed [10:0] exp_base, exp_r;
  logic [23:0]        man_r;

  always_comb begin
    inc      = round_inc(rm_p0, op_p1.sgn, op_p1.rnd, op_p1.stk, op_p1.man[0]);
    sum      = {1'b0, op_p1.man} + {24'd0, inc};
    exp_base = $signed({op_p1.exp[9], op_p1.exp});
    exp_r    = exp_base;
    man_r    = sum[23:0];
    if (sum[24]) begin
      man_r = sum[24:1];
      exp_r = exp_base + 11'sd1;
    end else if ((op_p1.exp == 10'd0) && sum[23]) begin
      // A subnormal that rounded up into the normal range.
      exp_r = 11'sd1;
    end
  end

  // ---- PACK: assemble the binary32 word and the flags ----
  always_comb begin
    logic nx;
    nx = nx_p2 | of_p2;
    if (of_p2)
      pack_res = {sgn_p2, ovf_to_inf(rm_p0, sgn_p2) ? FPU_INF : FPU_MAX_FINITE};
    else if (man_p2 == 24'd0)
      pack_res = {sgn_p2, 31'd0};
    else
      pack_res = {sgn_p2, exp_p2, man_p2[22:0]};
    pack_flags              = '0;
    pack_flags[FPU_FLAG_NV] = iv_p0;
    pack_flags[FPU_FLAG_OF] = of_p2;
    pack_flags[FPU_FLAG_UF] = nx & (pack_res[30:23] == 8'd0);
    pack_flags[FPU_FLAG_NX] = nx;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      result_q    <= '0;
      fflags_q    <= '0;
      ready_fin_q <= 1'b0;
    end else begin
      ready_fin_q <= 1'b0;
      if (load && final_in) begin
        result_q    <= {sgn_in, exp_in[7:0], man_in[22:0]};
        fflags_q    <= {iv_in, 4'b0000};
        ready_fin_q <= 1'b1;
      end else if (state_q == S_PACK) begin
        result_q <= pack_res;
        fflags_q <= pack_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      op_p0 <= '{sgn: sgn_in, exp: exp_in, man: man_in, rnd: round_in, stk: sticky_in};
      rm_p0 <= rm;
      iv_p0 <= iv_in;
    end
    if (state_q == S_DENORM) begin
      op_p1  <= denorm_d;
      ftz_p1 <= ftz_d;
    end
    if (state_q == S_ROUND) begin
      sgn_p2 <= op_p1.sgn;
      exp_p2 <= exp_r[7:0];
      man_p2 <= man_r;
      nx_p2  <= op_p1.rnd | op_p1.stk | ftz_p1;
      of_p2  <= (exp_r >= 11'sd255);
    end
  end

  // In PACK the freshly packed word is shown directly; afterwards it is held.
  assign ready  = ready_fin_q | (state_q == S_PACK);
  assign busy   = (state_q != S_IDLE);
  assign result = (state_q == S_PACK) ? pack_res : result_q;
  assign fflags = (state_q == S_PACK) ? pack_flags : fflags_q;

endmodule

// File: tb/tb_airi5c_float_rounder.sv
module tb_airi5c_float_rounder;

  logic        clk = 1'b0;
  logic        reset, kill, load;
  logic [2:0]  rm;
  logic [23:0] man_in;
  logic [9:0]  exp_in;
  logic        sgn_in, round_in, sticky_in, iv_in, final_in;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic        ready, busy;

  airi5c_float_rounder dut (
    .clk(clk), .reset(reset), .kill(kill), .load(load), .rm(rm),
    .man_in(man_in), .exp_in(exp_in), .sgn_in(sgn_in), .round_in(round_in),
    .sticky_in(sticky_in), .iv_in(iv_in), .final_in(final_in),
    .result(result), .fflags(fflags), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef FPU_FLUSH_TO_ZERO_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [23:0] man;
    logic [9:0]  exp;
    logic        sgn, r, s;
    logic [2:0]  rm;
    logic        iv, fin;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  flg;
    int          rdy_cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic add_vec(input string tag, input logic [23:0] man, input logic [9:0] exp,
                         input logic sgn, input logic r, input logic s, input logic [2:0] m,
                         input logic iv, input logic fin, input logic [31:0] res, input logic [4:0] flg);
    vec_t v;
    v = '{tag: tag, man: man, exp: exp, sgn: sgn, r: r, s: s, rm: m,
          iv: iv, fin: fin, res: res, flg: flg};
    vecs.push_back(v);
  endtask

  // Drives one load cycle at a falling edge; optionally scores its result.
  task automatic drive(input vec_t v, input bit score);
    man_in = v.man; exp_in = v.exp; sgn_in = v.sgn; round_in = v.r;
    sticky_in = v.s; rm = v.rm; iv_in = v.iv; final_in = v.fin; load = 1'b1;
    if (score) begin
      exp_t e;
      e = '{tag: v.tag, res: v.res, flg: v.flg, rdy_cyc: cyc + (v.fin ? 1 : 3)};
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ready) begin
      if (sb.size() == 0) begin
        check_val("spurious_ready", {31'd0, ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val({e.tag, "_res"}, result, e.res);
        check_val({e.tag, "_flags"}, {27'd0, fflags}, {27'd0, e.flg});
        check_val({e.tag, "_latency"}, cyc, e.rdy_cyc);
      end
    end
  end

  initial begin
    reset = 1'b1; kill = 1'b0; load = 1'b0; rm = 3'd0; man_in = '0; exp_in = '0;
    sgn_in = 1'b0; round_in = 1'b0; sticky_in = 1'b0; iv_in = 1'b0; final_in = 1'b0;

    //       tag     man        exp      sgn r  s  rm      iv fin result                       flags
    add_vec("rne_tie_even", 24'hC00000, 10'd127, 0, 1, 0, 3'b000, 0, 0, 32'h3FC00000, 5'h01);
    add_vec("rne_up",   24'hC00001, 10'd127, 0, 1, 0, 3'b000, 0, 0, 32'h3FC00002, 5'h01);
    add_vec("carry",    24'hFFFFFF, 10'd127, 0, 1, 0, 3'b000, 0, 0, 32'h40000000, 5'h01);
    add_vec("ovf_rne",  24'hFFFFFF, 10'd254, 0, 1, 0, 3'b000, 0, 0, 32'h7F800000, 5'h05);
    add_vec("max_rtz",  24'hFFFFFF, 10'd254, 0, 1, 0, 3'b001, 0, 0, 32'h7F7FFFFF, 5'h01);
    add_vec("sub_ex",   24'h800000, 10'h3FF, 0, 0, 0, 3'b000, 0, 0,
            FTZ ? 32'h0 : 32'h00200000, FTZ ? 5'h03 : 5'h00);
    add_vec("sub_nx",   24'h800000, 10'h3FF, 0, 1, 0, 3'b000, 0, 0,
            FTZ ? 32'h0 : 32'h00200000, 5'h03);
    add_vec("final_nv", 24'hC00000, 10'h0FF, 0, 0, 0, 3'b000, 1, 1, 32'h7FC00000, 5'h10);
    add_vec("ovf_rdn_neg", 24'hFFFFFF, 10'd254, 1, 1, 0, 3'b010, 0, 0, 32'hFF800000, 5'h05);
    add_vec("ovf_rup_neg", 24'h800000, 10'd255, 1, 0, 0, 3'b011, 0, 0, 32'hFF7FFFFF, 5'h05);
    add_vec("exact",    24'h800000, 10'd100, 0, 0, 0, 3'b000, 0, 0, 32'h32000000, 5'h00);
    add_vec("rmm",      24'h800000, 10'd127, 0, 1, 0, 3'b100, 0, 0, 32'h3F800001, 5'h01);
    add_vec("rup_pos",  24'h800000, 10'd127, 0, 0, 1, 3'b011, 0, 0, 32'h3F800001, 5'h01);
    add_vec("rdn_pos",  24'h800000, 10'd127, 0, 0, 1, 3'b010, 0, 0, 32'h3F800000, 5'h01);
    add_vec("rm_illegal", 24'h800001, 10'd127, 0, 1, 0, 3'b111, 0, 0, 32'h3F800002, 5'h01);
    add_vec("sub_to_norm", 24'hFFFFFF, 10'd0, 0, 1, 0, 3'b000, 0, 0,
            FTZ ? 32'h0 : 32'h00800000, FTZ ? 5'h03 : 5'h01);
    add_vec("neg_zero", 24'h000000, 10'd50, 1, 0, 0, 3'b000, 0, 0, 32'h80000000, 5'h00);
    add_vec("deep_rne", 24'h800000, 10'h39C, 0, 0, 0, 3'b000, 0, 0, 32'h00000000, 5'h03);
    add_vec("deep_rup", 24'h800000, 10'h39C, 0, 0, 0, 3'b011, 0, 0,
            FTZ ? 32'h0 : 32'h00000001, 5'h03);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("reset_result", result, 32'd0);
    check_val("reset_fflags", {27'd0, fflags}, 32'd0);
    check_val("reset_ready", {31'd0, ready}, 32'd0);
    check_val("reset_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i], 1'b1);
      @(negedge clk);
      load = 1'b0;
      check_val({vecs[i].tag, "_busy"}, {31'd0, busy}, {31'd0, !vecs[i].fin});
      repeat (3) @(negedge clk);
    end

    // Kill one cycle after load: no result, outputs cleared.
    @(negedge clk);
    drive(vecs[1], 1'b0);
    @(negedge clk);
    load = 1'b0;
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    repeat (5) @(negedge clk);
    check_val("kill_result", result, 32'd0);
    check_val("kill_fflags", {27'd0, fflags}, 32'd0);
    check_val("kill_busy", {31'd0, busy}, 32'd0);

    // Restart two cycles into an operation: only the second result appears.
    @(negedge clk);
    drive(vecs[1], 1'b0);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    drive(vecs[2], 1'b1);
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check_val("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
